// File: rtl/decoder_nto2n_seq_if.sv
// Select/decode bus of the registered N-to-2^N decoder.
// The master drives the request side; the slave (the decoder) drives the registered results.
interface decoder_nto2n_seq_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2 ** SEL_W;

    logic [SEL_W-1:0] din;
    logic             en;
    logic [1:0]       mode;
    logic             sweep_start;
    logic [OUT_W-1:0] y;
    logic             y_valid;
    logic             sweep_busy;
    logic             sweep_done;
    logic             err;

    modport master (
        output din, en, mode, sweep_start,
        input  y, y_valid, sweep_busy, sweep_done, err
    );

    modport slave (
        input  din, en, mode, sweep_start,
        output y, y_valid, sweep_busy, sweep_done, err
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N decoder with one-hot / thermometer / broadcast modes and an
// auto-sweep sequencer that walks a single one across every output (register-file clear).
module decoder_nto2n_seq #(
    parameter int SEL_W     = 3,
    parameter int SWEEP_GAP = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_nto2n_seq_if.slave   bus
);
    localparam int OUT_W    = 2 ** SEL_W;
    localparam int GAP_LAST = (SWEEP_GAP > 0) ? SWEEP_GAP - 1 : 0;
    localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, GAP, DONE} state_t;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] cnt_reg, cnt_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [OUT_W-1:0] y_reg, y_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] sweep_hot;

    // Per-bit decode; thermometer bit gi is set for every din at or above gi.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
        assign onehot[gi]    = (bus.din == SEL_W'(gi));
        assign therm[gi]     = (bus.din >= SEL_W'(gi));
        assign sweep_hot[gi] = (cnt_reg == SEL_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        y_next     = '0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.sweep_start) begin
                    // Sweep request wins; any concurrent decode is dropped.
                    state_next = SWEEP;
                    cnt_next   = '0;
                    gap_next   = '0;
                end else if (bus.en) begin
                    case (bus.mode)
                        2'b00: begin
                            y_next     = onehot;
                            valid_next = 1'b1;
                        end
                        2'b01: begin
                            y_next     = therm;
                            valid_next = 1'b1;
                        end
                        2'b10: begin
                            y_next     = '1;
                            valid_next = 1'b1;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end

            SWEEP: begin
                y_next     = sweep_hot;
                valid_next = 1'b1;
                busy_next  = 1'b1;
                if (cnt_reg == SEL_W'(OUT_W - 1)) begin
                    state_next = DONE;
                end else if (SWEEP_GAP > 0) begin
                    state_next = GAP;
                    gap_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            GAP: begin
                busy_next = 1'b1;
                if (gap_reg == GAP_W'(GAP_LAST)) begin
                    gap_next   = '0;
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = SWEEP;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            DONE: begin
                done_next  = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            gap_reg   <= '0;
            y_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
            y_reg     <= y_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign bus.y          = y_reg;
    assign bus.y_valid    = valid_reg;
    assign bus.sweep_busy = busy_reg;
    assign bus.sweep_done = done_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench for decoder_nto2n_seq: three instances (SEL_W=3 gap 0, SEL_W=3 gap 2, SEL_W=4 gap 0)
// driven with a vector table and hand-written sweep/reset sequences, checked through a queue.
module tb_decoder_nto2n_seq;
    logic clk;
    logic rst_n;

    decoder_nto2n_seq_if #(.SEL_W(3)) if0 ();
    decoder_nto2n_seq_if #(.SEL_W(3)) if1 ();
    decoder_nto2n_seq_if #(.SEL_W(4)) if2 ();

    decoder_nto2n_seq #(.SEL_W(3), .SWEEP_GAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    decoder_nto2n_seq #(.SEL_W(3), .SWEEP_GAP(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    decoder_nto2n_seq #(.SEL_W(4), .SWEEP_GAP(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          which;
        logic [15:0] y;
        logic        v;
        logic        b;
        logic        d;
        logic        e;
        string       name;
    } exp_t;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [3:0]  din;
        logic [15:0] y;
        logic        v;
        logic        e;
        string       name;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [19:0] actual(input int which);
        logic [19:0] r;
        case (which)
            0:       r = {8'h00, if0.y, if0.y_valid, if0.sweep_busy, if0.sweep_done, if0.err};
            1:       r = {8'h00, if1.y, if1.y_valid, if1.sweep_busy, if1.sweep_done, if1.err};
            default: r = {if2.y, if2.y_valid, if2.sweep_busy, if2.sweep_done, if2.err};
        endcase
        return r;
    endfunction

    task automatic drive(input int which, input logic en_i, input logic [1:0] mode_i,
                         input logic [3:0] din_i, input logic start_i);
        case (which)
            0: begin
                if0.en = en_i; if0.mode = mode_i; if0.din = din_i[2:0]; if0.sweep_start = start_i;
            end
            1: begin
                if1.en = en_i; if1.mode = mode_i; if1.din = din_i[2:0]; if1.sweep_start = start_i;
            end
            default: begin
                if2.en = en_i; if2.mode = mode_i; if2.din = din_i; if2.sweep_start = start_i;
            end
        endcase
    endtask

    task automatic push(input int which, input logic [15:0] y, input logic v, input logic b,
                        input logic d, input logic e, input string name);
        exp_t x;
        x.which = which; x.y = y; x.v = v; x.b = b; x.d = d; x.e = e; x.name = name;
        sb_q.push_back(x);
    endtask

    task automatic check_head();
        exp_t        x;
        logic [19:0] act;
        logic [19:0] exp_v;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            x     = sb_q.pop_front();
            act   = actual(x.which);
            exp_v = {x.y, x.v, x.b, x.d, x.e};
            $display("check dut%0d %s: y=%h v=%b busy=%b done=%b err=%b", x.which, x.name,
                     act[19:4], act[3], act[2], act[1], act[0]);
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got y=%h v=%b busy=%b done=%b err=%b, required y=%h v=%b busy=%b done=%b err=%b",
                         x.name, x.which, act[19:4], act[3], act[2], act[1], act[0],
                         x.y, x.v, x.b, x.d, x.e);
            end
        end
    endtask

    // One transaction: drive at the falling edge, expect the result 1 clock later.
    task automatic step(input int which, input logic en_i, input logic [1:0] mode_i,
                        input logic [3:0] din_i, input logic start_i,
                        input logic [15:0] y, input logic v, input logic b,
                        input logic d, input logic e, input string name);
        @(negedge clk);
        drive(which, en_i, mode_i, din_i, start_i);
        push(which, y, v, b, d, e, name);
        @(posedge clk);
        #1;
        check_head();
    endtask

    task automatic add_vec(input logic en_i, input logic [1:0] mode_i, input logic [3:0] din_i,
                           input logic [15:0] y, input logic v, input logic e, input string name);
        vec_t t;
        t.en = en_i; t.mode = mode_i; t.din = din_i; t.y = y; t.v = v; t.e = e; t.name = name;
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] one16;
        one16 = 16'h0001;

        for (int i = 0; i < 8; i++) add_vec(1'b1, 2'b00, 4'(i), one16 << i, 1'b1, 1'b0, "onehot");
        add_vec(1'b0, 2'b00, 4'd7, 16'h0000, 1'b0, 1'b0, "en_low");
        add_vec(1'b1, 2'b01, 4'd3, 16'h000F, 1'b1, 1'b0, "therm_d3");
        add_vec(1'b1, 2'b01, 4'd7, 16'h00FF, 1'b1, 1'b0, "therm_d7");
        add_vec(1'b1, 2'b01, 4'd0, 16'h0001, 1'b1, 1'b0, "therm_d0");
        add_vec(1'b1, 2'b10, 4'd5, 16'h00FF, 1'b1, 1'b0, "broadcast");
        add_vec(1'b1, 2'b11, 4'd2, 16'h0000, 1'b0, 1'b1, "reserved");
        add_vec(1'b0, 2'b11, 4'd2, 16'h0000, 1'b0, 1'b0, "err_pulse_end");

        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) drive(w, 1'b1, 2'b10, 4'd0, 1'b0);
        #3;
        for (int w = 0; w < 3; w++) begin
            push(w, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
            check_head();
        end
        @(negedge clk);
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 2'b00, 4'd0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[k])
            step(0, vecs[k].en, vecs[k].mode, vecs[k].din, 1'b0,
                 vecs[k].y, vecs[k].v, 1'b0, 1'b0, vecs[k].e, vecs[k].name);

        // Asynchronous reset mid-cycle with en still high.
        step(0, 1'b1, 2'b10, 4'd0, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, "pre_reset");
        #2 rst_n = 1'b0;
        #1;
        push(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset");
        check_head();
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep, gap 0, sweep_start held high and en active throughout.
        step(0, 1'b1, 2'b10, 4'd3, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "start_prio");
        for (int i = 0; i < 8; i++)
            step(0, 1'b1, 2'b00, 4'd5, 1'b1, one16 << i, 1'b1, 1'b1, 1'b0, 1'b0, "sweep0");
        step(0, 1'b1, 2'b00, 4'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "sweep0_done");
        step(0, 1'b1, 2'b00, 4'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "rearm_idle");
        for (int i = 0; i < 4; i++)
            step(0, 1'b0, 2'b00, 4'd0, 1'b0, one16 << i, 1'b1, 1'b1, 1'b0, 1'b0, "resweep");

        // Reset while y=0x08: everything clears, no done pulse, restart from 0x01.
        #2 rst_n = 1'b0;
        #1;
        push(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "midsweep_reset");
        check_head();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b0, 2'b00, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_a");
        step(0, 1'b0, 2'b00, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_b");
        step(0, 1'b0, 2'b00, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "restart");
        step(0, 1'b0, 2'b00, 4'd0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, "restart_first");

        // Sweep with two gap cycles between steps.
        step(1, 1'b0, 2'b00, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "gap_start");
        for (int i = 0; i < 8; i++) begin
            step(1, 1'b1, 2'b01, 4'd7, 1'b0, one16 << i, 1'b1, 1'b1, 1'b0, 1'b0, "gap_step");
            if (i < 7) begin
                step(1, 1'b1, 2'b01, 4'd7, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "gap_idle1");
                step(1, 1'b1, 2'b01, 4'd7, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "gap_idle2");
            end
        end
        step(1, 1'b1, 2'b01, 4'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "gap_done");
        step(1, 1'b1, 2'b01, 4'd2, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, "gap_after");

        // Wider select.
        step(2, 1'b1, 2'b01, 4'd9,  1'b0, 16'h03FF, 1'b1, 1'b0, 1'b0, 1'b0, "w4_therm9");
        step(2, 1'b1, 2'b00, 4'd15, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, "w4_onehot15");
        step(2, 1'b1, 2'b10, 4'd1,  1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, "w4_broadcast");
        step(2, 1'b1, 2'b01, 4'd15, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, "w4_therm15");
        step(2, 1'b0, 2'b01, 4'd15, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "w4_idle");

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
Parametrised registered N-to-2^N decoder. It drives register-file write enables and peripheral selects in the RISC16 datapath.
- Adds three output modes: one-hot, thermometer and broadcast.
- Adds an auto-sweep sequencer that walks a single one across every output, used to clear the register file after reset.
- All outputs are registered, giving fully synchronous, glitch-free selects.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable); legal range 1..6.
SWEEP_GAP, 0, idle cycles inserted between consecutive sweep steps (0 = one step per clock).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
din  input  SEL_W  select index
en  input  1  decode request, sampled each rising edge
mode  input  2  00 one-hot, 01 thermometer, 10 broadcast, 11 reserved
sweep_start  input  1  start auto-sweep (level sampled, acted on only in IDLE)
y  output  OUT_W  registered decoded output
y_valid  output  1  y carries a live decode this cycle
sweep_busy  output  1  sweep in progress
sweep_done  output  1  one-cycle pulse after the final sweep step
err  output  1  one-cycle pulse: reserved mode requested

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, y_valid=0, sweep_busy=0, sweep_done=0, err=0.
  - FSM=IDLE; sweep counter=0; gap counter=0.
  - Deassertion is taken synchronously on the next rising edge.
- Latency: exactly 1 clock from sampled en/din/mode to y/y_valid. Every input is sampled on each edge; y is never Z and never latched from a stale din.
- FSM states: IDLE, SWEEP, GAP, DONE.
- IDLE:
  - sweep_start=1: go to SWEEP, counter=0. This takes priority over en in the same cycle; the decode request is dropped and y=0, y_valid=0 that cycle.
  - else en=1, mode=00: y has only bit din set; y_valid=1.
  - else en=1, mode=01: y bits [din:0] set, all others 0 (din=0 gives 1; din=OUT_W-1 gives all ones); y_valid=1.
  - else en=1, mode=10: y all ones, din ignored; y_valid=1.
  - else en=1, mode=11: y=0, y_valid=0, err=1 for one cycle.
  - else en=0: y=0, y_valid=0. No hold of the previous value.
- SWEEP:
  - y has only bit counter set; y_valid=1; sweep_busy=1.
  - en, din, mode and sweep_start are ignored.
  - counter==OUT_W-1: go to DONE.
  - else if SWEEP_GAP>0: go to GAP.
  - else counter+1, stay in SWEEP.
- GAP:
  - y=0, y_valid=0, sweep_busy=1.
  - After SWEEP_GAP cycles: counter+1, go to SWEEP.
- DONE:
  - y=0, y_valid=0, sweep_busy=0, sweep_done=1 for one cycle; go to IDLE.
  - sweep_start held high re-arms only after it is seen in IDLE, so the next sweep begins no earlier than 2 cycles after sweep_done.
- Sweep length: OUT_W steps, plus (OUT_W-1)*SWEEP_GAP gap cycles, plus 1 DONE cycle. The counter is SEL_W bits and never wraps inside a sweep.
- Reset mid-sweep: all state cleared immediately; no sweep_done pulse.
- y_valid=0 always implies y=0.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with en=1 -> y=0x00, y_valid=0 immediately (asynchronous), before any clock edge.
- One-hot sweep of din, SEL_W=3, mode=00, en=1, din=0..7 on consecutive edges -> y=0x01,0x02,...,0x80 one cycle later each, y_valid=1; then en=0 -> y=0x00 next cycle.
- Thermometer and broadcast: mode=01, din=3 -> y=0x0F; din=7 -> y=0xFF; din=0 -> y=0x01. mode=10, din=5 -> y=0xFF. mode=11 -> y=0x00, y_valid=0, err pulses for 1 cycle.
- Auto-sweep, SWEEP_GAP=0: sweep_start pulse -> y=0x01..0x80 over 8 consecutive cycles; sweep_busy high for those 8 cycles; sweep_done on the 9th cycle; en=1 asserted during the sweep has no effect.
- Auto-sweep, SWEEP_GAP=2: y=0x01,0,0,0x02,0,0,...,0x80 -> 22 cycles busy, then sweep_done.
- Reset mid-sweep: rst_n=0 while y=0x08 -> all outputs 0, no sweep_done. After release, sweep_start restarts from y=0x01.
- Parameter check: SEL_W=4, mode=01, din=9 -> y=0x03FF.
